// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch hazard control, bubble gating and halt-on-illegal sequencing
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic [1:0]  ctl_wb,
  input  logic [2:0]  ctl_mem,
  input  logic [3:0]  ctl_ex,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        exmem_branch,
  input  logic        exmem_zero,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        pcsrc,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  id_wb,
  output logic [2:0]  id_mem,
  output logic [3:0]  id_ex,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, DRAIN = 2'b01, HALT = 2'b10} st_t;
  st_t st;
  logic [5:0] op;
  logic take, legal, uses_rt, lu, br, freeze, stall;
  assign op = id_instr[31:26];
  assign take = exmem_branch & exmem_zero;
  assign legal = op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04;
  assign uses_rt = op == 6'h00 || op == 6'h2b || op == 6'h04;
  assign lu = idex_memread && idex_rt != 5'd0 &&
              (idex_rt == id_instr[25:21] || (uses_rt && idex_rt == id_instr[20:16]));
  // a taken branch overrides everything except HALT, since ID holds wrong-path code
  assign br = take && (st == RUN || st == DRAIN);
  assign freeze = !br && (st != RUN || !legal || lu);
  assign stall = st == RUN && !take && legal && lu;
  assign pc_write = !freeze;
  assign ifid_write = !freeze;
  assign pcsrc = br;
  assign ifid_flush = br;
  assign exmem_flush = br;
  assign idex_flush = br | freeze;
  assign id_wb = idex_flush ? 2'b0 : ctl_wb;
  assign id_mem = idex_flush ? 3'b0 : ctl_mem;
  assign id_ex = idex_flush ? 4'b0 : ctl_ex;
  assign state = st;
  assign halted = st == HALT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (br && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      case (st)
        RUN:     st <= (!take && !legal) ? DRAIN : RUN;
        DRAIN:   st <= take ? RUN : HALT;
        default: st <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks against a rule-level model of hazard_ctrl
module tb_hazard_ctrl;
  logic        clk = 0, rst = 1;
  logic [31:0] id_instr = 32'h00441820;
  logic [1:0]  ctl_wb = 2'b01;
  logic [2:0]  ctl_mem = 3'b000;
  logic [3:0]  ctl_ex = 4'hC;
  logic        idex_memread = 0;
  logic [4:0]  idex_rt = 0;
  logic        exmem_branch = 0, exmem_zero = 0;
  logic        pc_write, ifid_write, pcsrc, ifid_flush, idex_flush, exmem_flush, halted;
  logic [1:0]  id_wb, state;
  logic [2:0]  id_mem;
  logic [3:0]  id_ex;
  logic [15:0] stall_cnt, flush_cnt;
  int          n_total = 0, n_pass = 0;
  int          m_mode = 0, m_stall = 0, m_flush = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ctl_wb(ctl_wb), .ctl_mem(ctl_mem),
    .ctl_ex(ctl_ex), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .pc_write(pc_write),
    .ifid_write(ifid_write), .pcsrc(pcsrc), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .id_wb(id_wb), .id_mem(id_mem),
    .id_ex(id_ex), .state(state), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // mode: 0 running, 1 one cycle after an illegal opcode, 2 halted
  function automatic void model(input int mode, output logic [14:0] o, output bit si,
                                output bit fi, output int nm);
    logic [5:0] op = id_instr[31:26];
    bit take = exmem_branch && exmem_zero;
    bit legal = op inside {6'h00, 6'h23, 6'h2b, 6'h04};
    bit urt = op inside {6'h00, 6'h2b, 6'h04};
    bit lu = idex_memread && idex_rt != 0 &&
             (idex_rt == id_instr[25:21] || (urt && idex_rt == id_instr[20:16]));
    bit frz = 0, br = 0;
    nm = mode; si = 0; fi = 0;
    if (mode == 2) frz = 1;
    else if (take) begin br = 1; fi = 1; nm = 0; end
    else if (mode == 1) begin frz = 1; nm = 2; end
    else if (!legal) begin frz = 1; nm = 1; end
    else if (lu) begin frz = 1; si = 1; end
    o = {!frz, !frz, br, br, br | frz, br, (br | frz) ? 9'd0 : {ctl_wb, ctl_mem, ctl_ex}};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [14:0] o;
    bit si, fi;
    int nm;
    if (rst) begin
      m_mode <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      model(m_mode, o, si, fi, nm);
      m_mode <= nm;
      if (si && m_stall < 65535) m_stall <= m_stall + 1;
      if (fi && m_flush < 65535) m_flush <= m_flush + 1;
    end
  end

  always @(negedge clk) begin
    logic [14:0] o;
    bit si, fi;
    int nm;
    if (!rst) begin
      model(m_mode, o, si, fi, nm);
      chk("comb", {49'd0, pc_write, ifid_write, pcsrc, ifid_flush, idex_flush, exmem_flush,
                   id_wb, id_mem, id_ex}, {49'd0, o});
      chk("regs", {29'd0, state, halted, stall_cnt, flush_cnt},
          {29'd0, m_mode[1:0], m_mode == 2, m_stall[15:0], m_flush[15:0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_instr = 32'h00441820; idex_memread = 0; idex_rt = 0;
    exmem_branch = 0; exmem_zero = 0;
  endtask

  task automatic do_reset();
    #1 rst = 1;
    #1 rst = 0;
  endtask

  initial begin
    #1;
    chk("rst_state", state, 2'b00);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 32'd0);
    chk("rst_halted", halted, 1'b0);
    tick();
    rst = 0;
    tick();
    chk("idle_pc", {pc_write, ifid_write, idex_flush}, 3'b110);
    chk("idle_ex", id_ex, 4'hC);
    idex_memread = 1; idex_rt = 2;
    #2 chk("lu_freeze", {pc_write, ifid_write, idex_flush, id_wb, id_ex}, {3'b001, 6'd0});
    tick();
    idle();
    #2 chk("lu_cnt", stall_cnt, 16'd1);
    chk("lu_after", pc_write, 1'b1);
    idex_memread = 1; idex_rt = 0;
    #2 chk("rt0_nostall", pc_write, 1'b1);
    tick();
    chk("rt0_cnt", stall_cnt, 16'd1);
    idex_rt = 2; exmem_branch = 1; exmem_zero = 1;
    #2 chk("take_lu", {pcsrc, ifid_flush, idex_flush, exmem_flush, pc_write}, 5'b11111);
    tick();
    idle();
    #2 chk("take_cnt", {stall_cnt, flush_cnt}, {16'd1, 16'd1});
    id_instr = 32'hFC000000;
    #2 chk("ill_freeze", {pc_write, ifid_write, idex_flush}, 3'b001);
    tick();
    idle();
    #2 chk("drain", state, 2'b01);
    tick();
    chk("halt", {state, halted}, 3'b101);
    exmem_branch = 1; exmem_zero = 1;
    #2 chk("halt_take", {pcsrc, pc_write, idex_flush}, 3'b001);
    tick();
    chk("halt_stay", state, 2'b10);
    do_reset();
    chk("halt_rst", {state, halted}, 3'b000);
    idle();
    id_instr = 32'hFC000000;
    tick();
    idle();
    exmem_branch = 1; exmem_zero = 1;
    #2 chk("drain_take", {state, pcsrc, exmem_flush}, 4'b0111);
    tick();
    idle();
    chk("drain_ret", {state, flush_cnt}, {2'b00, 16'd1});
    do_reset();
    idex_memread = 1; idex_rt = 2;
    for (int i = 0; i < 65540; i++) tick();
    chk("sat", stall_cnt, 16'hFFFF);
    #2 rst = 1;
    #1 chk("async_rst", stall_cnt, 16'd0);
    rst = 0;
    idle();
    for (int i = 0; i < 3000; i++) begin
      tick();
      case ($urandom_range(0, 9))
        0:       id_instr = $urandom;
        1, 2:    id_instr = {6'h23, 26'($urandom)};
        3:       id_instr = {6'h2b, 26'($urandom)};
        4:       id_instr = {6'h04, 26'($urandom)};
        default: id_instr = {6'h00, 26'($urandom)};
      endcase
      id_instr[25:16] = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ctl_wb = 2'($urandom); ctl_mem = 3'($urandom); ctl_ex = 4'($urandom);
      idex_memread = $urandom_range(0, 1) == 1;
      idex_rt = 5'($urandom_range(0, 3));
      exmem_branch = $urandom_range(0, 2) == 0;
      exmem_zero = $urandom_range(0, 1) == 1;
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the ID stage and consumes the decoded control bundle (wb/mem/ex) for the instruction in IF/ID, plus ID/EX and EX/MEM status. It drives PC/IF-ID write enables, stage flushes and branch PC select, and gates the control bundle into ID/EX, inserting bubbles on load-use stalls and taken branches. It also halts the pipeline cleanly on an unsupported opcode and keeps saturating stall/flush statistics.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_instr  in  32  instruction held in IF/ID
- ctl_wb  in  2  decoded wb bits for id_instr (bit1 MemtoReg, bit0 RegWrite)
- ctl_mem  in  3  decoded mem bits (bit2 Branch, bit1 MemRead, bit0 MemWrite)
- ctl_ex  in  4  decoded ex bits
- idex_memread  in  1  MemRead bit currently in ID/EX
- idex_rt  in  5  rt field currently in ID/EX
- exmem_branch  in  1  Branch bit currently in EX/MEM
- exmem_zero  in  1  ALU zero flag currently in EX/MEM
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- pcsrc  out  1  1 = PC loads branch target
- ifid_flush  out  1  clear IF/ID to nop
- idex_flush  out  1  load a bubble into ID/EX
- exmem_flush  out  1  load a bubble into EX/MEM
- id_wb  out  2  gated wb bits to ID/EX
- id_mem  out  3  gated mem bits to ID/EX
- id_ex  out  4  gated ex bits to ID/EX
- state  out  2  FSM state: RUN=00, DRAIN=01, HALT=10
- halted  out  1  state == HALT
- stall_cnt  out  16  load-use stall cycles, saturating
- flush_cnt  out  16  taken-branch flushes, saturating

## Operation
- Definitions: op = id_instr[31:26]; take = exmem_branch & exmem_zero; legal = op in {0x00, 0x23, 0x2b, 0x04}; uses_rt = op in {0x00, 0x2b, 0x04}; lu = idex_memread & (idex_rt != 0) & ((idex_rt == id_instr[25:21]) | (uses_rt & idex_rt == id_instr[20:16])).
- Default (no event): pc_write=1, ifid_write=1, all others 0.
- Bubble: whenever idex_flush=1, id_wb/id_mem/id_ex are all zero; otherwise they equal ctl_*. This also zeroes X bundles from illegal opcodes.
- RUN, priority from highest to lowest:
  - take: pcsrc=1, pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1; flush_cnt++. Illegal opcode and lu are ignored because ID is wrong-path.
  - !legal: pc_write=0, ifid_write=0, idex_flush=1; next state DRAIN.
  - lu: pc_write=0, ifid_write=0, idex_flush=1; stall_cnt++.
- DRAIN (exactly 1 cycle; the instruction older than the illegal one is now in MEM):
  - take: same outputs as the RUN take case; flush_cnt++; next state RUN.
  - else: pc_write=0, ifid_write=0, idex_flush=1; next state HALT.
- HALT: pc_write=0, ifid_write=0, idex_flush=1. All inputs are ignored, including take. Only rst exits.
- Counters: increment by 1 on a qualifying cycle; hold at 0xFFFF.

## Timing
- Control outputs (pc_write, ifid_write, pcsrc, flushes, id_*) are combinational from the inputs and the current state, with no register stage. They are valid in the same cycle, so the pipeline registers sample them at the next edge.
- state, stall_cnt and flush_cnt are registered and update on the rising clk edge after the qualifying cycle.
- A load-use stall lasts exactly one cycle: the bubble clears idex_memread on the next cycle. Back-to-back lu is possible only with new ID/EX content.
- Illegal opcode: detection cycle D freezes the pipeline. D+1 is DRAIN. D+2 onward is HALT, unless take occurs at D+1.
- Reset (asynchronous, any cycle including DRAIN): state=RUN, stall_cnt=0, flush_cnt=0, halted=0. Combinational outputs then follow the RUN equations; with idle inputs pc_write=1, ifid_write=1 and all else 0.

## Test plan
- Reset then idle, with id_instr=add (op 0x00) and no hazards -> pc_write=1, ifid_write=1, id_* = ctl_*, state=00, counters 0.
- lw $2 in ID/EX (idex_memread=1, idex_rt=2), add $3,$2,$4 in ID -> one cycle of pc_write=0, ifid_write=0, idex_flush=1, id_*=0; stall_cnt=1; the next cycle runs normally. Repeat with idex_rt=0 -> no stall.
- take=1 together with a load-use hazard in the same cycle -> pcsrc=1, all three flushes asserted, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- op=0x3F in ID, no branch -> freeze; state goes 01 then 10, halted=1; pipeline stays frozen under a later take=1; rst returns state to 00.
- op=0x3F in ID, take=1 on the following cycle (DRAIN) -> pcsrc=1 and flushes asserted, state returns to 00, flush_cnt=1.
- Force 65,536 load-use stalls -> stall_cnt holds at 0xFFFF. Assert rst mid-sequence -> stall_cnt=0 immediately (asynchronous).
